// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory bus between the cpu and the GEMM accelerator DMA.
// One access is in flight at a time; a BUSY phase that runs too long is aborted with an error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_cs,
    input  logic        cpu_rd_wr,
    input  logic [3:0]  cpu_mask,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_valid,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,

    input  logic        acc_cs,
    input  logic        acc_rd_wr,
    input  logic [3:0]  acc_mask,
    input  logic [31:0] acc_addr,
    input  logic [31:0] acc_wdata,
    output logic        acc_valid,
    output logic        acc_err,
    output logic [31:0] acc_rdata,

    output logic        mem_cs,
    output logic        mem_rd_wr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,

    output logic        busy,
    output logic        owner
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q;

    // Requester views indexed by port: 0 = cpu, 1 = acc
    logic [1:0]        req_cs;
    logic [1:0]        req_rd_wr;
    logic [1:0][3:0]   req_mask;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;

    logic              grant;
    logic              last_q;
    logic              owner_q;
    logic              busy_q;

    logic              mem_cs_q;
    logic              mem_rd_wr_q;
    logic [3:0]        mem_mask_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic [1:0]        valid_q;
    logic [1:0]        err_q;
    logic [1:0][31:0]  rdata_q;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;

    assign req_cs    = {acc_cs,    cpu_cs};
    assign req_rd_wr = {acc_rd_wr, cpu_rd_wr};
    assign req_mask  = {acc_mask,  cpu_mask};
    assign req_addr  = {acc_addr,  cpu_addr};
    assign req_wdata = {acc_wdata, cpu_wdata};

    // Contention goes to whoever was not granted last; a lone requester always wins.
    assign grant = (&req_cs) ? ~last_q : req_cs[1];

    assign cnt_inc     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign timeout_hit = (cnt_inc == (CNT_W+1)'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_rd_wr_q <= 1'b0;
            mem_mask_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_cs) begin
                        owner_q     <= grant;
                        last_q      <= grant;
                        mem_rd_wr_q <= req_rd_wr[grant];
                        mem_mask_q  <= req_mask[grant];
                        mem_addr_q  <= req_addr[grant];
                        mem_wdata_q <= req_wdata[grant];
                        mem_cs_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A completion strobe in the timeout cycle still counts as success.
                    if (mem_valid) begin
                        rdata_q[owner_q] <= mem_rdata;
                        err_q[owner_q]   <= 1'b0;
                        valid_q[owner_q] <= 1'b1;
                        mem_cs_q         <= 1'b0;
                        state_q          <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_inc[CNT_W-1:0];
                        if (timeout_hit) begin
                            rdata_q[owner_q] <= '0;
                            err_q[owner_q]   <= 1'b1;
                            valid_q[owner_q] <= 1'b1;
                            mem_cs_q         <= 1'b0;
                            state_q          <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    mem_cs_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_valid = valid_q[0];
    assign cpu_err   = err_q[0];
    assign cpu_rdata = rdata_q[0];
    assign acc_valid = valid_q[1];
    assign acc_err   = err_q[1];
    assign acc_rdata = rdata_q[1];

    assign mem_cs    = mem_cs_q;
    assign mem_rd_wr = mem_rd_wr_q;
    assign mem_mask  = mem_mask_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign busy  = busy_q;
    assign owner = owner_q;

`ifndef SYNTHESIS
    a_single_valid: assert property (@(posedge clk) disable iff (!reset) !(cpu_valid && acc_valid));
    a_cs_implies_busy: assert property (@(posedge clk) disable iff (!reset) mem_cs |-> busy);
    a_valid_not_cs: assert property (@(posedge clk) disable iff (!reset) (cpu_valid || acc_valid) |-> !mem_cs);
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum BUSY cycles before an access is aborted; legal range 1..65535.
REQ-002 Ports use one clock; reset is asynchronous and active-low (clk, reset).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_cs, cpu_rd_wr  input  1,1  core request; rd_wr 1=read, 0=write.
REQ-006 cpu_mask, cpu_addr, cpu_wdata  input  4,32,32  core byte mask, address, store data.
REQ-007 cpu_valid, cpu_err  output  1,1  core completion pulse; abort flag.
REQ-008 cpu_rdata  output  32  core read data.
REQ-009 acc_cs, acc_rd_wr, acc_mask, acc_addr, acc_wdata  input  1,1,4,32,32  GEMM accelerator DMA request, same meaning as the cpu_* inputs.
REQ-010 acc_valid, acc_err, acc_rdata  output  1,1,32  accelerator completion, abort flag, read data.
REQ-011 mem_cs, mem_rd_wr, mem_mask, mem_addr, mem_wdata  output  1,1,4,32,32  shared memory bus request.
REQ-012 mem_rdata, mem_valid  input  32,1  memory read data; one-cycle completion strobe.
REQ-013 busy, owner  output  1,1  transaction in flight; owner 0=cpu, 1=acc.

Function
REQ-014 FSM states IDLE, BUSY, RESP; the block holds at most one outstanding transaction.
REQ-015 IDLE: if any *_cs is high, the block latches the winner's rd_wr/mask/addr/wdata, sets owner, and enters BUSY on the next edge.
REQ-016 Arbitration is round-robin: when both request, the grant goes to the requester not granted last; a lone requester always wins.
REQ-017 The last-grant pointer resets to acc, so the cpu wins the first simultaneous request.
REQ-018 BUSY: mem_cs=1 with the latched fields held stable; the live requester inputs have no effect.
REQ-019 BUSY with mem_valid=1: capture mem_rdata, clear err, enter RESP.
REQ-020 BUSY timeout counter: cleared on BUSY entry and incremented each BUSY cycle without mem_valid; on reaching TIMEOUT_CYC, rdata=0, err=1, enter RESP.
REQ-021 If mem_valid and the timeout occur in the same cycle, mem_valid wins (err=0, data captured).
REQ-022 RESP lasts one cycle: mem_cs=0; the owner's *_valid=1 with *_rdata and *_err; enter IDLE.
REQ-023 The non-owner's *_valid stays 0.
REQ-024 *_rdata holds its last captured value outside RESP; for writes it carries the captured mem_rdata, which is a don't-care.
REQ-025 Latency: request in IDLE at cycle 0, mem_cs at cycle 1, mem_valid at cycle k, *_valid at cycle k+1, IDLE at cycle k+2; a new grant's mem_cs can assert no earlier than cycle k+3.
REQ-026 Requesters hold *_cs until their *_valid. A requester dropping cs mid-transaction does not cancel it; completion is still pulsed.
REQ-027 mem_valid in IDLE or RESP is ignored.
REQ-028 busy=1 in BUSY and RESP; owner is held until the next grant.
REQ-029 mem_* outputs are registered; mem_cs=0 in IDLE and RESP.

Reset
REQ-030 While reset=0, regardless of clock: state=IDLE, and mem_cs, *_valid, *_err, busy, owner(0), the timeout counter, and all data outputs are 0; the last-grant pointer is acc.
REQ-031 Reset asserted mid-transaction aborts it: no *_valid pulse is issued, and mem_cs drops asynchronously.
REQ-032 On reset release, the first arbitration happens on the first rising edge with reset=1.

Verification
REQ-033 cpu read addr 0x100, memory returns 0xDEADBEEF with mem_valid 3 cycles after mem_cs -> mem_addr=0x100, mem_rd_wr=1; cpu_valid one pulse one cycle after mem_valid, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-034 cpu and acc both request from reset, held -> grants alternate cpu, acc, cpu, acc; owner toggles; no starvation over 8 transactions.
REQ-035 acc write addr 0x2000 wdata 0x12345678 mask 0xF, mem_valid never asserted, TIMEOUT_CYC=4 -> mem_cs high exactly 4 cycles; acc_valid=1, acc_err=1, acc_rdata=0; then IDLE.
REQ-036 mem_valid coincides with the timeout cycle -> err=0, rdata captured.
REQ-037 Stray mem_valid while IDLE -> no *_valid pulse.
REQ-038 reset dropped while BUSY, then released -> mem_cs=0 immediately, no *_valid pulse, next cpu request granted normally.
